wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the MEM/WB pipeline stage and a long-latency

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the MEM/WB stage and a
//   long-latency unit (LU, the mul/div result queue). Pipeline writes win.
//   When an LU result has been blocked for MAX_WAIT cycles, a one-cycle
//   pipeline stall is forced so that a bubble reaches MEM/WB and the LU can
//   write in that slot.
//
//   Handshake: the LU presents lu_valid with lu_rd/lu_data held stable; the
//   result is consumed in the cycle where lu_valid & lu_ready are both high.
//   lu_ready is combinational. A result addressed to x0 is acknowledged
//   immediately and never written.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   pipe_valid/rd/data       MEM/WB write request
//   lu_valid/rd/data         LU result; lu_ready acknowledges it
//   pipe_stall               registered; high exactly while in STALL
//   rf_we/rf_rd/rf_wdata     registered register-file write port
//   protocol_err             sticky; pipe write seen in the bubble slot
//   stall_events             saturating count of forced stalls
//   dbg_state, dbg_wait_cnt  FSM state and starvation counter for debug
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              protocol_err,
    output logic [15:0]       stall_events,
    output logic [1:0]        dbg_state,
    output logic [7:0]        dbg_wait_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_SLOT  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              stall_q;
    logic [15:0]       events_q;
    logic              we_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] wdata_q;

    logic pipe_req;
    logic lu_nz;
    logic lu_grant;
    logic blocked;

    // A pipe write to x0 is not a request, so it never blocks the LU.
    assign pipe_req = pipe_valid & (pipe_rd != '0);
    assign lu_nz    = (lu_rd != '0);
    // The LU only writes when the pipe is not using the port; in the bubble
    // slot a (contract-violating) pipe write still wins.
    assign lu_grant = lu_valid & lu_nz & ~pipe_req;
    assign blocked  = lu_valid & lu_nz & pipe_req;
    // Gated by rst so a grant pending at reset is dropped.
    assign lu_ready = ~rst & ((lu_valid & ~lu_nz) | lu_grant);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (blocked) begin
                    wait_cnt_d = 8'd1;
                    if (MAX_WAIT == 1) state_d = ST_STALL;
                    else               state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lu_grant) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (blocked) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q + 8'd1 == MAX_WAIT_C) state_d = ST_STALL;
                end else begin
                    // LU withdrew its request (only possible around reset).
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_STALL: begin
                // The in-flight pipe write still owns the port this cycle.
                if (lu_grant) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (pipe_req) begin
                    // Bubble did not land: pipe wins, flag it, stall again.
                    err_d   = 1'b1;
                    state_d = ST_STALL;
                end else begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
            events_q   <= 16'd0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            stall_q    <= (state_d == ST_STALL);
            if ((state_d == ST_STALL) && (events_q != 16'hFFFF))
                events_q <= events_q + 16'd1;
            we_q <= lu_grant | pipe_req;
            if (lu_grant) begin
                rd_q    <= lu_rd;
                wdata_q <= lu_data;
            end else if (pipe_req) begin
                rd_q    <= pipe_rd;
                wdata_q <= pipe_data;
            end
        end
    end

    assign pipe_stall   = stall_q;
    assign rf_we        = we_q;
    assign rf_rd        = rd_q;
    assign rf_wdata     = wdata_q;
    assign protocol_err = err_q;
    assign stall_events = events_q;
    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter (DATA_W=32, ADDR_W=5, MAX_WAIT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge against a cycle-level model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              protocol_err;
    logic [15:0]       stall_events;
    logic [1:0]        dbg_state;
    logic [7:0]        dbg_wait_cnt;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .protocol_err(protocol_err), .stall_events(stall_events),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: consecutive blocked cycles, stall/slot flags, expected port
    int          m_run;
    bit          m_stall, m_slot, m_err;
    int          m_events;
    bit          m_we;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wdata;

    always @(negedge clk) begin
        bit preq, grant, blk, exp_ready, nstall, nslot;
        if (rst) begin
            m_run = 0; m_stall = 0; m_slot = 0; m_err = 0; m_events = 0;
            m_we = 0; m_rd = '0; m_wdata = '0;
        end
        preq      = pipe_valid && (pipe_rd != 0);
        grant     = lu_valid && (lu_rd != 0) && !preq;
        blk       = lu_valid && (lu_rd != 0) && preq;
        exp_ready = !rst && lu_valid && ((lu_rd == 0) || !preq);
        chk("lu_ready", 32'(lu_ready), 32'(exp_ready));
        chk("pipe_stall", 32'(pipe_stall), 32'(m_stall));
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("protocol_err", 32'(protocol_err), 32'(m_err));
        chk("stall_events", 32'(stall_events), 32'(m_events));
        if (!rst) begin
            nstall = 0;
            if (m_slot && preq) begin
                m_err  = 1;
                nstall = 1;
            end else if (!m_stall && !m_slot && blk) begin
                m_run++;
                if (m_run == MAX_WAIT) nstall = 1;
            end else if (!blk) begin
                m_run = 0;
            end
            if (nstall || grant) m_run = 0;
            nslot = m_stall && !grant;
            if (nstall && m_events < 65535) m_events++;
            m_stall = nstall;
            m_slot  = nslot;
            m_we    = grant || preq;
            if (grant) begin
                m_rd = lu_rd; m_wdata = lu_data;
            end else if (preq) begin
                m_rd = pipe_rd; m_wdata = pipe_data;
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input bit v, input int rd, input logic [31:0] d);
        pipe_valid = v; pipe_rd = ADDR_W'(rd); pipe_data = d;
    endtask

    task automatic drive_lu(input bit v, input int rd, input logic [31:0] d);
        lu_valid = v; lu_rd = ADDR_W'(rd); lu_data = d;
    endtask

    // Pipe writes for MAX_WAIT+1 cycles against a blocked LU; returns in
    // the bubble cycle with inputs not yet changed for it.
    task automatic starve(input int prd, input int lrd, input logic [31:0] ldat);
        drive_lu(1, lrd, ldat);
        for (int k = 0; k <= MAX_WAIT; k++) begin
            drive_pipe(1, prd, 32'h1000 * prd + k);
            if (k == MAX_WAIT) begin
                @(negedge clk);
                chk("lit_stall_high", 32'(pipe_stall), 32'd1);
                chk("lit_lu_blocked", 32'(lu_ready), 32'd0);
            end
            cyc();
        end
    endtask

    initial begin
        // 1: reset with every input active
        rst = 1'b1;
        drive_pipe(1, 3, 32'h3333);
        drive_lu(1, 9, 32'h9999);
        repeat (3) cyc();
        @(negedge clk);
        chk("lit_rst_we", 32'(rf_we), 32'd0);
        chk("lit_rst_ready", 32'(lu_ready), 32'd0);
        chk("lit_rst_wdata", rf_wdata, 32'd0);
        cyc();
        drive_pipe(0, 0, 0);
        drive_lu(0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_idle_state", 32'(dbg_state), 32'd0);
        cyc();

        // 2: free port, LU writes immediately
        drive_lu(1, 7, 32'hDEAD);
        @(negedge clk);
        chk("lit_free_ready", 32'(lu_ready), 32'd1);
        cyc();
        drive_lu(0, 0, 0);
        @(negedge clk);
        chk("lit_free_we", 32'(rf_we), 32'd1);
        chk("lit_free_rd", 32'(rf_rd), 32'd7);
        chk("lit_free_wdata", rf_wdata, 32'hDEAD);
        cyc();

        // 3: starvation -> forced stall -> bubble
        starve(3, 9, 32'h900D);
        drive_pipe(0, 0, 0);
        @(negedge clk);
        chk("lit_bubble_ready", 32'(lu_ready), 32'd1);
        chk("lit_bubble_nostall", 32'(pipe_stall), 32'd0);
        cyc();
        drive_lu(0, 0, 0);
        @(negedge clk);
        chk("lit_lu_rd", 32'(rf_rd), 32'd9);
        chk("lit_lu_wdata", rf_wdata, 32'h900D);
        chk("lit_events1", 32'(stall_events), 32'd1);
        cyc();

        // 4: x0 handling
        drive_pipe(1, 0, 32'hBAD);
        drive_lu(1, 5, 32'h55);
        cyc();
        drive_pipe(0, 0, 0);
        drive_lu(1, 0, 32'h77);
        @(negedge clk);
        chk("lit_x0_lu_rd", 32'(rf_rd), 32'd5);
        chk("lit_x0_ready", 32'(lu_ready), 32'd1);
        cyc();
        drive_lu(0, 0, 0);
        @(negedge clk);
        chk("lit_x0_no_we", 32'(rf_we), 32'd0);
        chk("lit_x0_hold_rd", 32'(rf_rd), 32'd5);
        cyc();

        // 5: pipe write in the bubble slot
        starve(4, 10, 32'hA);
        drive_pipe(1, 6, 32'h66);
        @(negedge clk);
        chk("lit_slot_pipe_wins", 32'(lu_ready), 32'd0);
        cyc();
        drive_pipe(1, 6, 32'h67);
        @(negedge clk);
        chk("lit_err_rd", 32'(rf_rd), 32'd6);
        chk("lit_err_flag", 32'(protocol_err), 32'd1);
        chk("lit_restall", 32'(pipe_stall), 32'd1);
        cyc();
        drive_pipe(0, 0, 0);
        cyc();
        drive_lu(0, 0, 0);
        @(negedge clk);
        chk("lit_err_lu_rd", 32'(rf_rd), 32'd10);
        chk("lit_events3", 32'(stall_events), 32'd3);
        chk("lit_err_sticky", 32'(protocol_err), 32'd1);
        cyc();

        // 6: reset in the middle of WAIT
        drive_lu(1, 11, 32'hB);
        drive_pipe(1, 2, 32'h22);
        repeat (2) cyc();
        drive_pipe(1, 2, 32'h23);
        @(negedge clk);
        chk("lit_wait_cnt2", 32'(dbg_wait_cnt), 32'd2);
        cyc();
        rst = 1'b1;
        #1;
        chk("lit_mid_state", 32'(dbg_state), 32'd0);
        chk("lit_mid_cnt", 32'(dbg_wait_cnt), 32'd0);
        chk("lit_mid_stall", 32'(pipe_stall), 32'd0);
        chk("lit_mid_events", 32'(stall_events), 32'd0);
        chk("lit_mid_err", 32'(protocol_err), 32'd0);
        drive_pipe(0, 0, 0);
        drive_lu(0, 0, 0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
